// File: rtl/spi_txn_arbiter.sv
// Two-requester SPI register sequencer: round-robin grant, ss_n framing, a
// {rw,addr} command byte plus one data byte through a shared byte engine.
module spi_txn_arbiter #(
   parameter int ADDR_W      = 7,
   parameter int SETUP_CYC   = 2,
   parameter int HOLD_CYC    = 2,
   parameter int GAP_CYC     = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [7:0]        wdata0,
   input  logic [7:0]        wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic              ss_n,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_done,
   input  logic [7:0]        rx_data
);
   localparam int         WD_W      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0] SETUP_END = 8'(SETUP_CYC);
   localparam logic [7:0] HOLD_END  = 8'(HOLD_CYC - 1);
   localparam logic [7:0] GAP_END   = 8'(GAP_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, HOLD, GAP} state_t;

   state_t            state;
   logic              last_grant, owner, rw_q, abort;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q, rx_hold, cnt;
   logic [WD_W-1:0]   wd;
   logic              pick1, byte_done, byte_timeout;

   assign pick1        = req1 && (!req0 || !last_grant);
   // the engine needs at least one cycle, so a done alongside our own start is stale
   assign byte_done    = tx_done && !tx_start;
   assign byte_timeout = (wd == WD_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         rw_q       <= 1'b0;
         abort      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         rx_hold    <= 8'h00;
         cnt        <= 8'd0;
         wd         <= '0;
         ss_n       <= 1'b1;
         busy       <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err        <= 1'b0;
         rdata      <= 8'h00;
      end else begin
         tx_start <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: if (req0 || req1) begin
               owner      <= pick1;
               last_grant <= pick1;
               rw_q       <= pick1 ? rw1 : rw0;
               addr_q     <= pick1 ? addr1 : addr0;
               wdata_q    <= pick1 ? wdata1 : wdata0;
               abort      <= 1'b0;
               cnt        <= 8'd1;
               ss_n       <= 1'b0;
               busy       <= 1'b1;
               state      <= SETUP;
            end
            SETUP: if (cnt >= SETUP_END) begin
               state    <= CMD;
               tx_start <= 1'b1;
               tx_data  <= {rw_q, 7'(addr_q)};
               wd       <= '0;
            end else begin
               cnt <= cnt + 8'd1;
            end
            CMD: if (byte_done) begin
               state    <= DATA;
               tx_start <= 1'b1;
               tx_data  <= rw_q ? 8'h00 : wdata_q;
               wd       <= '0;
            end else if (byte_timeout) begin
               abort <= 1'b1;
               cnt   <= 8'd1;
               state <= HOLD;
            end else begin
               wd <= wd + WD_W'(1);
            end
            DATA: if (byte_done) begin
               if (rw_q) rx_hold <= rx_data;
               cnt   <= 8'd1;
               state <= HOLD;
            end else if (byte_timeout) begin
               abort <= 1'b1;
               cnt   <= 8'd1;
               state <= HOLD;
            end else begin
               wd <= wd + WD_W'(1);
            end
            // the byte-complete cycle already counts as the first hold cycle
            HOLD: if (cnt >= HOLD_END) begin
               state <= GAP;
               ss_n  <= 1'b1;
               ack0  <= !owner;
               ack1  <= owner;
               err   <= abort;
               if (rw_q && !abort) rdata <= rx_hold;
               cnt   <= 8'd1;
            end else begin
               cnt <= cnt + 8'd1;
            end
            // the IDLE arbitration cycle is the last ss_n-high cycle of the gap
            GAP: if (cnt >= GAP_END) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: scripted byte engine, event monitor and a
// transaction-level model of expected framing, order, timing and read data.
module tb_spi_txn_arbiter;
   localparam int SETUP = 2, HOLD = 2, GAP = 3, TMO = 64;

   logic       clk, reset, req0, req1, rw0, rw1;
   logic [6:0] addr0, addr1;
   logic [7:0] wdata0, wdata1, rdata, tx_data, rx_data;
   logic       ack0, ack1, err, busy, ss_n, tx_start, tx_done;

   spi_txn_arbiter #(.ADDR_W(7), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD),
                     .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy), .ss_n(ss_n),
      .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .rx_data(rx_data));

   int checks = 0, errors = 0;
   int cyc = 0;
   // engine script and monitor records
   int         eng_n1 = 1, eng_n2 = 1;
   logic [7:0] eng_rx = 8'h00;
   bit         glitch_en = 0;
   logic [7:0] byte_q[$];
   int         st_q[$];
   int  fall_cyc = 0, rise_cyc = -1, last_gap = -1, due = -1;
   int  ack_cnt = 0, ack_idx = 0, ack_cyc = 0;
   bit  ack_err = 0, ack_ss = 0, prev_ack = 0, prev_ss = 1;
   logic [7:0] ack_rd = 8'h00;
   int  viol_start = 0, viol_busy = 0, viol_ack = 0;
   // reference model state
   int         model_last = 1;
   logic [7:0] model_rdata = 8'h00;

   initial begin clk = 0; forever #5 clk = ~clk; end
   initial forever @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic int pick(input bit r0, input bit r1);
      if (r0 && (!r1 || model_last == 1)) return 0;
      return 1;
   endfunction

   // engine + monitor: sampled and driven on the falling edge
   initial begin
      int n;
      tx_done = 0; rx_data = 8'h00;
      forever begin
         @(negedge clk);
         tx_done = 0;
         if (prev_ss && ss_n === 1'b0) begin
            if (rise_cyc >= 0) last_gap = cyc - rise_cyc;
            fall_cyc = cyc;
            byte_q.delete();
            st_q.delete();
            due = -1;
         end
         if (!prev_ss && ss_n === 1'b1) rise_cyc = cyc;
         prev_ss = (ss_n !== 1'b0);
         if (tx_start === 1'b1 && ss_n !== 1'b0) viol_start++;
         if (ss_n === 1'b0 && busy !== 1'b1) viol_busy++;
         if (err === 1'b1 && !(ack0 === 1'b1 || ack1 === 1'b1)) viol_ack++;
         if (ack0 === 1'b1 || ack1 === 1'b1) begin
            if ((ack0 === 1'b1 && ack1 === 1'b1) || prev_ack) viol_ack++;
            ack_idx = (ack1 === 1'b1) ? 1 : 0;
            ack_err = (err === 1'b1);
            ack_ss  = (ss_n === 1'b1);
            ack_rd  = rdata;
            ack_cyc = cyc;
            ack_cnt++;
            prev_ack = 1;
         end else prev_ack = 0;
         if (tx_start === 1'b1) begin
            n = (byte_q.size() == 0) ? eng_n1 : eng_n2;
            byte_q.push_back(tx_data);
            st_q.push_back(cyc);
            due = (n == 0) ? -1 : cyc + n;
            if (glitch_en && $urandom_range(0, 1) == 1) begin
               tx_done = 1; rx_data = 8'($urandom);
            end
         end else if (due == cyc) begin
            tx_done = 1;
            rx_data = (byte_q.size() == 2) ? eng_rx : 8'($urandom);
            due = -1;
         end else if (glitch_en && ss_n === 1'b1 && $urandom_range(0, 3) == 0) begin
            tx_done = 1; rx_data = 8'($urandom);
         end
      end
   end

   task automatic do_reset(input int n);
      reset = 1; req0 = 0; req1 = 0;
      tick(n);
      reset = 0;
      model_last = 1;
      model_rdata = 8'h00;
   endtask

   // wait for the next ack and compare the finished transaction with the model
   task automatic expect_ack(input string tag, input int idx, input bit rw, input logic [6:0] a,
                             input logic [7:0] wd, input int n1, input int n2,
                             input logic [7:0] rx, input bit gap_chk);
      int base, w, dur;
      bit to;
      base = ack_cnt; w = 0; to = (n1 == 0);
      while (ack_cnt == base && w < 400) begin tick(); w++; end
      if (ack_cnt == base) begin chk({tag, "_ack_wait"}, 0, 1); return; end
      chk({tag, "_idx"}, ack_idx, idx);
      chk({tag, "_err"}, 32'(ack_err), 32'(to));
      chk({tag, "_ss_at_ack"}, 32'(ack_ss), 1);
      chk({tag, "_nbytes"}, byte_q.size(), to ? 1 : 2);
      if (byte_q.size() > 0) begin
         chk({tag, "_cmd"}, byte_q[0], {rw, a});
         chk({tag, "_setup"}, st_q[0] - fall_cyc, SETUP);
      end
      if (!to && byte_q.size() > 1) begin
         chk({tag, "_data"}, byte_q[1], rw ? 8'h00 : wd);
         chk({tag, "_start2"}, st_q[1] - fall_cyc, SETUP + n1 + 1);
      end
      dur = to ? SETUP + TMO + HOLD : SETUP + n1 + n2 + HOLD + 1;
      chk({tag, "_ss_low"}, ack_cyc - fall_cyc, dur);
      if (rw && !to) model_rdata = rx;
      chk({tag, "_rdata"}, ack_rd, model_rdata);
      if (gap_chk) chk({tag, "_gap"}, last_gap, GAP);
      model_last = idx;
   endtask

   initial begin
      int base, w, rv, o;
      reset = 1; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      do_reset(3);
      reset = 1;
      tick();
      chk("rst_ss_n", ss_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_ack", {ack0, ack1, err}, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_rdata", rdata, 8'h00);
      reset = 0;
      tick(2);

      // write from requester 0
      eng_n1 = 16; eng_n2 = 16;
      rw0 = 0; addr0 = 7'h05; wdata0 = 8'hA5; req0 = 1;
      expect_ack("wr", 0, 0, 7'h05, 8'hA5, 16, 16, 8'h00, 0);
      req0 = 0;
      tick(4);

      // read from requester 1
      eng_rx = 8'h3C;
      rw1 = 1; addr1 = 7'h12; req1 = 1;
      expect_ack("rd", 1, 1, 7'h12, 8'h00, 16, 16, 8'h3C, 0);
      req1 = 0;
      tick(10);
      chk("rd_hold", rdata, 8'h3C);

      // contention from reset, both held: 0,1,0,1 with exact gaps
      do_reset(2);
      rw0 = 0; addr0 = 7'h21; wdata0 = 8'h5A;
      rw1 = 1; addr1 = 7'h44;
      eng_n1 = 3; eng_n2 = 5; eng_rx = 8'hC3;
      req0 = 1; req1 = 1;
      for (int k = 0; k < 4; k++) begin
         w = pick(1, 1);
         expect_ack($sformatf("cont%0d", k), w, w ? rw1 : rw0, w ? addr1 : addr0,
                    w ? wdata1 : wdata0, 3, 5, 8'hC3, k > 0);
      end
      req0 = 0; req1 = 0;
      tick(6);

      // command byte never completes: watchdog abort, rdata keeps old value
      eng_n1 = 0;
      rw0 = 1; addr0 = 7'h33; req0 = 1;
      expect_ack("tmo", 0, 1, 7'h33, 8'h00, 0, 0, 8'h00, 0);
      req0 = 0;
      tick(6);

      // reset in the middle of the data byte
      eng_n1 = 16; eng_n2 = 16;
      rw0 = 0; addr0 = 7'h0A; wdata0 = 8'h77; req0 = 1;
      w = 0;
      while (byte_q.size() < 2 && w < 200) begin tick(); w++; end
      chk("mid_data_reached", byte_q.size(), 2);
      tick(3);
      base = ack_cnt;
      reset = 1; req0 = 0;
      tick();
      chk("mid_rst_ss_n", ss_n, 1);
      chk("mid_rst_busy", busy, 0);
      reset = 0;
      model_last = 1; model_rdata = 8'h00;
      tick(30);
      chk("mid_rst_noack", ack_cnt, base);
      req0 = 1;
      expect_ack("after_rst", 0, 0, 7'h0A, 8'h77, 16, 16, 8'h00, 0);
      req0 = 0;
      tick(4);

      // randomized traffic with stray tx_done pulses
      glitch_en = 1;
      for (int r = 0; r < 25; r++) begin
         rv = $urandom_range(1, 3);
         rw0 = 1'($urandom); addr0 = 7'($urandom); wdata0 = 8'($urandom);
         rw1 = 1'($urandom); addr1 = 7'($urandom); wdata1 = 8'($urandom);
         eng_n1 = $urandom_range(1, 24); eng_n2 = $urandom_range(1, 24);
         eng_rx = 8'($urandom);
         req0 = rv[0]; req1 = rv[1];
         w = pick(rv[0], rv[1]);
         expect_ack($sformatf("rnd%0d_a", r), w, w ? rw1 : rw0, w ? addr1 : addr0,
                    w ? wdata1 : wdata0, eng_n1, eng_n2, eng_rx, 0);
         if (w == 0) req0 = 0; else req1 = 0;
         if (rv == 3) begin
            o = 1 - w;
            eng_n1 = $urandom_range(1, 24); eng_n2 = $urandom_range(1, 24);
            eng_rx = 8'($urandom);
            expect_ack($sformatf("rnd%0d_b", r), o, o ? rw1 : rw0, o ? addr1 : addr0,
                       o ? wdata1 : wdata0, eng_n1, eng_n2, eng_rx, 1);
            req0 = 0; req1 = 0;
         end
         tick($urandom_range(1, 6));
      end
      glitch_en = 0;
      tick(4);
      chk("final_rdata", rdata, model_rdata);
      chk("start_while_ss_high", viol_start, 0);
      chk("busy_low_in_txn", viol_busy, 0);
      chk("ack_err_pulse", viol_ack, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
